// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;

  typedef enum logic {RUN, STALL} ctrl_state_t;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// rtl/ctrl_perf_cnt.sv - wrapping event counter, cleared by reset
module ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer: cache-miss freeze, load-use bubbles, redirect squash
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             ex_br_taken,
  input  logic             id_load_use,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ifetch_en,
  output logic             dmem_en,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_flush
);

  ctrl_state_t state;
  logic        i_done;
  logic        d_done;
  logic        i_hit;
  logic        d_hit;
  logic        i_ok;
  logic        d_ok;
  logic        adv;

  // A response only counts when its side actually has a request outstanding.
  assign i_hit = icache_read & icache_resp;
  assign d_hit = dcache_req & dcache_resp;
  assign i_ok  = ~icache_read | icache_resp | i_done;
  assign d_ok  = ~dcache_req | dcache_resp | d_done;
  assign adv   = i_ok & d_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!adv) begin
            state  <= STALL;
            i_done <= i_hit;
            d_done <= d_hit;
          end
        end
        STALL: begin
          if (adv) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
          end else begin
            if (i_hit) i_done <= 1'b1;
            if (d_hit) d_done <= 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          i_done <= 1'b0;
          d_done <= 1'b0;
        end
      endcase
    end
  end

  // Flags may still be set in the reset cycle, so reset forces the gates open.
  assign ifetch_en = reset | ~i_done;
  assign dmem_en   = reset | ~d_done;

  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (reset) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (adv) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (ex_br_taken) begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (id_load_use) begin
        flush_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (~adv),
    .count (perf_stall)
  );

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_cnt_bubble (
    .clk   (clk),
    .reset (reset),
    .inc   (adv & ~ex_br_taken & id_load_use),
    .count (perf_bubble)
  );

  ctrl_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (adv & ex_br_taken),
    .count (perf_flush)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  typedef enum int {C_RST, C_RUN, C_FRZ, C_BUB, C_RED} cls_t;

  typedef struct {
    string       tag;
    logic [4:0]  load;
    logic [1:0]  flush;
    logic [1:0]  gate;
    bit          chk_cnt;
    logic [31:0] st;
    logic [31:0] bu;
    logic [31:0] fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        icache_read = 1'b0;
  logic        icache_resp = 1'b0;
  logic        dcache_req = 1'b0;
  logic        dcache_resp = 1'b0;
  logic        ex_br_taken = 1'b0;
  logic        id_load_use = 1'b0;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, ifetch_en, dmem_en;
  logic [31:0] perf_stall, perf_bubble, perf_flush;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_st = 0;
  logic [31:0] m_bu = 0;
  logic [31:0] m_fl = 0;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .icache_read (icache_read),
    .icache_resp (icache_resp),
    .dcache_req  (dcache_req),
    .dcache_resp (dcache_resp),
    .ex_br_taken (ex_br_taken),
    .id_load_use (id_load_use),
    .load_pc     (load_pc),
    .load_if_id  (load_if_id),
    .load_id_ex  (load_id_ex),
    .load_ex_mem (load_ex_mem),
    .load_mem_wb (load_mem_wb),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .ifetch_en   (ifetch_en),
    .dmem_en     (dmem_en),
    .perf_stall  (perf_stall),
    .perf_bubble (perf_bubble),
    .perf_flush  (perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, push the expectation derived from the class, then pop and compare.
  task automatic step(input string tag, input logic rst, input logic ir, input logic irsp,
                      input logic dq, input logic drsp, input logic br, input logic lu,
                      input cls_t cls, input logic [1:0] gate, input bit chk_cnt);
    exp_t e;
    exp_t o;
    @(posedge clk);
    #1;
    reset = rst; icache_read = ir; icache_resp = irsp;
    dcache_req = dq; dcache_resp = drsp; ex_br_taken = br; id_load_use = lu;
    e.tag = tag; e.gate = gate; e.chk_cnt = chk_cnt;
    e.st = m_st; e.bu = m_bu; e.fl = m_fl;
    case (cls)
      C_RST:   begin e.load = 5'b00000; e.flush = 2'b11; end
      C_FRZ:   begin e.load = 5'b00000; e.flush = 2'b00; end
      C_BUB:   begin e.load = 5'b00111; e.flush = 2'b01; end
      C_RED:   begin e.load = 5'b11111; e.flush = 2'b11; end
      default: begin e.load = 5'b11111; e.flush = 2'b00; end
    endcase
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk({o.tag, ".load"}, 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 32'(o.load));
    chk({o.tag, ".flush"}, 32'({flush_if_id, flush_id_ex}), 32'(o.flush));
    chk({o.tag, ".gate"}, 32'({ifetch_en, dmem_en}), 32'(o.gate));
    if (o.chk_cnt) begin
      chk({o.tag, ".perf_stall"}, perf_stall, o.st);
      chk({o.tag, ".perf_bubble"}, perf_bubble, o.bu);
      chk({o.tag, ".perf_flush"}, perf_flush, o.fl);
    end
    case (cls)
      C_RST: begin m_st = 0; m_bu = 0; m_fl = 0; end
      C_FRZ: m_st = m_st + 1;
      C_BUB: m_bu = m_bu + 1;
      C_RED: m_fl = m_fl + 1;
      default: ;
    endcase
  endtask

  initial begin
    //    tag          rst ir irsp dq drsp br lu  class  gate  cnt
    step("rst0",       1, 0, 0, 0, 0, 0, 0, C_RST, 2'b11, 0);
    step("rst1",       1, 0, 0, 0, 0, 0, 0, C_RST, 2'b11, 1);
    step("rel",        0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    step("imiss0",     0, 1, 0, 0, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("imiss1",     0, 1, 0, 0, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("imiss2",     0, 1, 0, 0, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("imiss3",     0, 1, 0, 0, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("imiss4",     0, 1, 1, 0, 0, 0, 0, C_RUN, 2'b11, 1);
    step("imiss_post", 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    step("split0",     0, 1, 0, 1, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("split1",     0, 1, 1, 1, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("split2",     0, 1, 0, 1, 0, 0, 0, C_FRZ, 2'b01, 1);
    step("split3",     0, 1, 0, 1, 1, 0, 0, C_RUN, 2'b01, 1);
    step("split4",     0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    step("both_resp",  0, 1, 1, 1, 1, 0, 0, C_RUN, 2'b11, 1);
    step("stray_i0",   0, 0, 1, 1, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("stray_i1",   0, 0, 0, 1, 1, 0, 0, C_RUN, 2'b11, 1);
    step("stray_i2",   0, 1, 0, 0, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("stray_i3",   0, 1, 1, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    step("lduse",      0, 0, 0, 0, 0, 0, 1, C_BUB, 2'b11, 1);
    step("lduse_post", 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);
    step("redir_lu",   0, 0, 0, 0, 0, 1, 1, C_RED, 2'b11, 1);
    step("redir_post", 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    step("dstall0",    0, 0, 0, 1, 0, 1, 0, C_FRZ, 2'b11, 1);
    step("dstall1",    0, 0, 0, 1, 0, 1, 1, C_FRZ, 2'b11, 1);
    step("dstall2",    0, 0, 0, 1, 1, 1, 0, C_RED, 2'b11, 1);
    step("dstall_post",0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    step("rstst0",     0, 1, 0, 1, 1, 0, 0, C_FRZ, 2'b11, 1);
    step("rstst1",     0, 1, 0, 1, 0, 0, 0, C_FRZ, 2'b10, 1);
    step("rstst2",     1, 1, 0, 1, 0, 0, 0, C_RST, 2'b11, 1);
    step("rstst3",     0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);
    step("rstst4",     0, 0, 0, 1, 0, 0, 0, C_FRZ, 2'b11, 1);
    step("rstst5",     0, 0, 0, 1, 1, 0, 0, C_RUN, 2'b11, 1);
    step("final",      0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b11, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. Generates the `load` enables and flush (synchronous pipe-register reset) strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers, including `WB_pipe`. It freezes the pipeline across I-cache and D-cache misses, tracking which response has already arrived. It inserts load-use bubbles and squashes wrong-path instructions on EX redirects, and keeps three 32-bit performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: performance counter width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `icache_read` in 1: IF stage requests a fetch this cycle.
- `icache_resp` in 1: single-cycle I-cache completion pulse.
- `dcache_req` in 1: MEM stage holds a load or store.
- `dcache_resp` in 1: single-cycle D-cache completion pulse.
- `ex_br_taken` in 1: EX resolves a taken branch or jump (redirect).
- `id_load_use` in 1: ID instruction sources the rd of a load currently in EX.
- `load_pc` out 1: PC register enable.
- `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: pipe register enables.
- `flush_if_id`, `flush_id_ex` out 1 each: ORed into the pipe register `reset` to load a bubble.
- `ifetch_en` out 1: gates `icache_read`; low once the I-response is latched during a stall.
- `dmem_en` out 1: gates the D-cache request, with the same rule.
- `perf_stall` out CNT_W: count of cache-stall cycles.
- `perf_bubble` out CNT_W: count of load-use bubbles.
- `perf_flush` out CNT_W: count of redirects.

## Operation
- Per-cycle signals:
  - `i_ok = ~icache_read | icache_resp | i_done`
  - `d_ok = ~dcache_req | dcache_resp | d_done`
  - `adv = i_ok & d_ok`
- FSM states: `RUN`, `STALL`. Latched flags: `i_done`, `d_done`.
- `RUN`:
  - If `adv` is high, stay in `RUN`.
  - Otherwise go to `STALL`. Set `i_done <= icache_read & icache_resp` and `d_done <= dcache_req & dcache_resp`.
- `STALL`:
  - An arriving response sets its flag.
  - When `adv` is high, go to `RUN` and clear both flags.
- `ifetch_en = ~i_done` and `dmem_en = ~d_done`, so an already-served request is never reissued.
- `~adv`: all `load_*` are 0 and all `flush_*` are 0. The whole pipeline freezes; `ex_br_taken` and `id_load_use` are ignored.
- `adv & ex_br_taken`:
  - All `load_*` are 1.
  - `flush_if_id = flush_id_ex = 1`: the two wrong-path instructions are squashed.
  - `perf_flush` increments.
  - The redirect has priority over load-use.
- `adv & ~ex_br_taken & id_load_use`:
  - `load_pc = load_if_id = 0`.
  - `load_id_ex = load_ex_mem = load_mem_wb = 1`.
  - `flush_id_ex = 1`: a bubble enters EX.
  - `perf_bubble` increments.
- `adv`, no hazard: all `load_*` are 1, all flushes 0.
- `perf_stall` increments on every cycle with `~adv`.
- All counters wrap modulo 2^CNT_W.
- While `reset` is high:
  - All `load_*` are 0. `flush_if_id` and `flush_id_ex` are 1.
  - `ifetch_en = dmem_en = 1`.
- Reset during `STALL` abandons the miss:
  - Next state is `RUN`, both flags are cleared, all counters are cleared.
  - Re-issue is the caches' responsibility.

## Timing
- All enable, flush and gate outputs are combinational from the current state, the flags and this cycle's inputs. There is zero added latency: the decision applies at the same `clk` edge.
- State, flags and counters update at `posedge clk`. Counter values are visible the cycle after the event.
- Both responses in the same cycle: `adv`, so there is no `STALL` entry.
- I-response in cycle n, D-response in cycle n+k:
  - `ifetch_en` is low during cycles n+1 through n+k.
  - Advance happens in cycle n+k.
- A response pulse on a non-requesting side (for example `icache_resp` with `icache_read` low) is ignored and is not latched.
- Minimum stall is one cycle (`RUN` with `~adv`). There is no upper bound.

## Structure
- `pipeline_ctrl_pkg` holds:
  - `typedef enum logic {RUN, STALL} ctrl_state_t`
  - the `CNT_W` default
- Sub-module `ctrl_perf_cnt` (parameter `CNT_W`; ports `clk`, `reset`, `inc`, `count`) is instantiated three times.
- The FSM and the output logic stay in `pipeline_ctrl`.

## Test plan
- **Reset:** hold `reset` high for 2 cycles, then release with no requests. During reset, loads are 0, flushes are 1 and counters are 0. The first cycle after release has all loads 1.
- **I-miss:**
  - Stimulus: `icache_read` = 1 with `icache_resp` first pulsing at cycle 4.
  - Cycles 0–3: loads 0.
  - Cycle 4: loads 1.
  - `perf_stall` reads 4 afterwards.
- **Split responses:**
  - Stimulus: `dcache_req` and `icache_read` both high; `icache_resp` at cycle 1, `dcache_resp` at cycle 3.
  - `ifetch_en` is 0 in cycles 2–3.
  - Advance occurs in cycle 3, and `i_done` is cleared in cycle 4.
- **Load-use:** `id_load_use` = 1 for one cycle with no misses. `load_pc` = `load_if_id` = 0, `flush_id_ex` = 1, `load_mem_wb` = 1, and `perf_bubble` = 1.
- **Redirect vs. load-use:** `ex_br_taken` and `id_load_use` both high. Both flushes are 1, all loads are 1, `perf_flush` = 1 and `perf_bubble` = 0.
- **Redirect under stall:** `ex_br_taken` held high during a 3-cycle D-miss. No flush occurs until the advance cycle, then exactly one flush, and `perf_flush` = 1.
